aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 12 +
 rtl/aes_key_select.sv | 25 ++
 rtl/aes_round_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM state type and key-length helpers for the AES round controller.
package aes_pkg;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    function automatic int nr(input int nk);
        return nk + 6;
    endfunction

    function automatic int key_w(input int nk);
        return 128 * (nk + 7);
    endfunction
endpackage

// File: rtl/aes_key_select.sv
// aes_key_select: slices one 128-bit round key out of the flat expanded key schedule.
module aes_key_select
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic [key_w(NK)-1:0] key,
    input  logic [3:0]           round,
    output logic [127:0]         round_key
);
    localparam int R = nr(NK);

    // Padded to 16 entries so every 4-bit round index selects a defined value.
    logic [127:0] keys [16];

    for (genvar i = 0; i < 16; i++) begin : g_k
        if (i <= R) begin : g_v
            assign keys[i] = key[key_w(NK)-1-128*i -: 128];
        end else begin : g_z
            assign keys[i] = '0;
        end
    end

    assign round_key = keys[round];
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption sequencer driving an external round datapath,
// one round per clock, with valid/ready handshakes on plaintext and ciphertext.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [key_w(NK)-1:0] key,
    input  logic                 in_valid,
    input  logic [127:0]         in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [127:0]         out_data,
    input  logic                 out_ready,
    output logic [127:0]         rnd_state,
    output logic                 rnd_last,
    input  logic [127:0]         rnd_result,
    output logic                 busy,
    output logic [3:0]           round
);
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_round_ctrl: NK must be 4, 6 or 8");
    end

    localparam logic [3:0] LAST = 4'(nr(NK));

    state_t       state, state_nx;
    logic [127:0] block, block_nx;
    logic [3:0]   round_nx;
    logic [127:0] round_key;

    // round is 0 in IDLE, so the same selector yields the whitening key on transfer.
    aes_key_select #(.NK(NK)) u_key_select (
        .key       (key),
        .round     (round),
        .round_key (round_key)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign rnd_last  = state == ROUND && round == LAST;
    assign rnd_state = block;
    assign out_data  = block;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            block <= '0;
            round <= '0;
        end else begin
            state <= state_nx;
            block <= block_nx;
            round <= round_nx;
        end
    end

    always_comb begin
        state_nx = state;
        block_nx = block;
        round_nx = round;
        case (state)
            IDLE: if (in_valid) begin
                block_nx = in_data ^ round_key;
                round_nx = 4'd1;
                state_nx = ROUND;
            end
            ROUND: begin
                block_nx = rnd_result ^ round_key;
                round_nx = rnd_last ? 4'd0 : round + 4'd1;
                state_nx = rnd_last ? DONE : ROUND;
            end
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule
